// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub_pipe carry-chained add/subtract pipeline.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    // Per-stage control record; operand remainders and partial sums are sized per stage in the top.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] final_sum;
    logic             final_carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, data0, data1, mode, out_ready,
        input  in_ready, out_valid, final_sum, final_carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, data0, data1, mode, out_ready,
        output in_ready, out_valid, final_sum, final_carry_out, overflow, zero
    );
endinterface

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational adder slice with carry-in, carry-out and carry into the MSB.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);
    logic [CHUNK:0] full;

    assign full      = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};
    assign sum       = full[CHUNK-1:0];
    assign carry_out = full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit and its operand bits
    assign carry_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract, CHUNK bits per stage, valid/ready handshake and registered flags.
// Define ADDSUB_SATURATE_EN to clamp final_sum to signed max/min on overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    addsub_if.slave bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in0;
    logic             out_valid_reg;
    logic [WIDTH-1:0] final_sum_reg;
    logic             carry_reg;
    logic             overflow_reg;
    logic             zero_reg;

    // Mode is folded into the inverted B and the stage-0 carry-in, so it travels with the beat.
    assign en                  = !out_valid_reg || bus.out_ready;
    assign bus.in_ready        = en;
    assign b_eff               = (bus.mode == MODE_ADD) ? bus.data1 : ~bus.data1;
    assign carry_in0           = (bus.mode == MODE_SUB);
    assign bus.out_valid       = out_valid_reg;
    assign bus.final_sum       = final_sum_reg;
    assign bus.final_carry_out = carry_reg;
    assign bus.overflow        = overflow_reg;
    assign bus.zero            = zero_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : stg
        localparam int LO = gi * CHUNK;

        logic [WIDTH-LO-1:0] a_rem;
        logic [WIDTH-LO-1:0] b_rem;
        logic [LO+CHUNK-1:0] sum_next;
        logic [CHUNK-1:0]    s_sl;
        logic                c_in;
        logic                c_out;
        logic                c_msb;
        logic                v_in;

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a         (a_rem[CHUNK-1:0]),
            .b         (b_rem[CHUNK-1:0]),
            .carry_in  (c_in),
            .sum       (s_sl),
            .carry_out (c_out),
            .carry_msb (c_msb)
        );

        if (gi == 0) begin : g_src
            assign a_rem    = bus.data0;
            assign b_rem    = b_eff;
            assign c_in     = carry_in0;
            assign v_in     = bus.in_valid;
            assign sum_next = s_sl;
        end else begin : g_src
            assign a_rem    = stg[gi-1].g_reg.a_reg;
            assign b_rem    = stg[gi-1].g_reg.b_reg;
            assign c_in     = stg[gi-1].g_reg.ctrl_reg.carry;
            assign v_in     = stg[gi-1].g_reg.ctrl_reg.valid;
            assign sum_next = {s_sl, stg[gi-1].g_reg.sum_reg};
        end

        if (gi < STAGES - 1) begin : g_reg
            // Finished low slices ride along (deskew); unused high operand slices are shifted down (skew).
            stage_ctrl_t               ctrl_reg;
            logic [LO+CHUNK-1:0]       sum_reg;
            logic [WIDTH-LO-CHUNK-1:0] a_reg;
            logic [WIDTH-LO-CHUNK-1:0] b_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctrl_reg <= '0;
                    sum_reg  <= '0;
                    a_reg    <= '0;
                    b_reg    <= '0;
                end else if (en) begin
                    ctrl_reg <= '{valid: v_in, carry: c_out};
                    sum_reg  <= sum_next;
                    a_reg    <= a_rem[WIDTH-LO-1:CHUNK];
                    b_reg    <= b_rem[WIDTH-LO-1:CHUNK];
                end
            end
        end else begin : g_out
            logic             ovf;
            logic [WIDTH-1:0] res;

            assign ovf = c_out ^ c_msb;
`ifdef ADDSUB_SATURATE_EN
            // On overflow both operand MSBs agree, and that shared sign is the true result sign.
            always_comb begin
                res = sum_next;
                if (ovf) begin
                    res = a_rem[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign res = sum_next;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_reg <= 1'b0;
                    final_sum_reg <= '0;
                    carry_reg     <= 1'b0;
                    overflow_reg  <= 1'b0;
                    zero_reg      <= 1'b0;
                end else if (en) begin
                    out_valid_reg <= v_in;
                    final_sum_reg <= res;
                    carry_reg     <= c_out;
                    overflow_reg  <= ovf;
                    zero_reg      <= (res == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=8, CHUNK=4); honours ADDSUB_SATURATE_EN when defined.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W   = 8;
    localparam int C   = 4;
    localparam int LAT = W / C;

`ifdef ADDSUB_SATURATE_EN
    localparam logic [W-1:0] SUM_7F_01 = 8'h7F;
    localparam logic [W-1:0] SUM_80_01 = 8'h80;
`else
    localparam logic [W-1:0] SUM_7F_01 = 8'h80;
    localparam logic [W-1:0] SUM_80_01 = 8'h7F;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_if #(.WIDTH(W)) bus ();

    addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    logic         acc_s, fire_s, s_in_ready, s_out_valid, s_carry, s_ovf, s_zero;
    logic [W-1:0] s_sum;

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t        e;
        int          ua, ub, ur, sa, sb, sr;
        logic [31:0] urv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (m == MODE_ADD) begin
            ur      = ua + ub;
            sr      = sa + sb;
            e.carry = (ur >= (1 << W));
        end else begin
            ur      = ua - ub;
            sr      = sa - sb;
            e.carry = (ua >= ub);
        end
        e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        urv   = ur;
        e.sum = urv[W-1:0];
`ifdef ADDSUB_SATURATE_EN
        if (e.ovf) e.sum = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the inputs settle, score emits/accepts, advance to next negedge.
    task automatic step();
        exp_t e;
        #1;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_sum       = bus.final_sum;
        s_carry     = bus.final_carry_out;
        s_ovf       = bus.overflow;
        s_zero      = bus.zero;
        acc_s       = bus.in_valid && bus.in_ready;
        fire_s      = bus.out_valid && bus.out_ready;
        if (fire_s) begin
            check("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_sum",      s_sum,   e.sum);
                check("sb_carry",    s_carry, e.carry);
                check("sb_overflow", s_ovf,   e.ovf);
                check("sb_zero",     s_zero,  e.zero);
                $display("emit sum=%02h carry=%0b ovf=%0b zero=%0b", s_sum, s_carry, s_ovf, s_zero);
            end
        end
        if (acc_s) exp_q.push_back(model(bus.data0, bus.data1, bus.mode));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic single_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic m, input logic [W-1:0] e_sum, input logic e_c,
                               input logic e_o, input logic e_z);
        int lat;
        lat           = 0;
        bus.in_valid  = 1'b1;
        bus.data0     = a;
        bus.data1     = b;
        bus.mode      = m;
        bus.out_ready = 1'b1;
        step();
        check({tag, "_accept"}, acc_s, 1);
        bus.in_valid = 1'b0;
        fire_s       = 1'b0;
        while (!fire_s && lat < 10) begin
            lat++;
            step();
        end
        check({tag, "_latency"},  lat,     LAT);
        check({tag, "_sum"},      s_sum,   e_sum);
        check({tag, "_carry"},    s_carry, e_c);
        check({tag, "_overflow"}, s_ovf,   e_o);
        check({tag, "_zero"},     s_zero,  e_z);
    endtask

    logic [W-1:0] a_t[6];
    logic [W-1:0] b_t[6];
    logic [W-1:0] held_sum;
    logic         held_c, held_o, held_z;
    int           sent, got;

    initial begin
        bus.in_valid  = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.mode      = MODE_ADD;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid,       0);
        check("rst_sum",       bus.final_sum,       0);
        check("rst_carry",     bus.final_carry_out, 0);
        check("rst_overflow",  bus.overflow,        0);
        check("rst_zero",      bus.zero,            0);
        check("rst_in_ready",  bus.in_ready,        1);
        rst_n = 1'b1;
        @(negedge clk);

        single_beat("v41_add_c1", 8'h41, 8'hC1, MODE_ADD, 8'h02,     1'b1, 1'b0, 1'b0);
        single_beat("v7f_add_01", 8'h7F, 8'h01, MODE_ADD, SUM_7F_01, 1'b0, 1'b1, 1'b0);
        single_beat("v80_sub_01", 8'h80, 8'h01, MODE_SUB, SUM_80_01, 1'b1, 1'b1, 1'b0);
        single_beat("v55_sub_55", 8'h55, 8'h55, MODE_SUB, 8'h00,     1'b1, 1'b0, 1'b1);

        // Six back-to-back beats of alternating mode with the consumer stalled for cycles 3-5.
        for (int i = 0; i < 6; i++) begin
            a_t[i] = W'($urandom());
            b_t[i] = W'($urandom());
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && (sent < 6 || got < 6); cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            bus.in_valid  = (sent < 6);
            if (sent < 6) begin
                bus.data0 = a_t[sent];
                bus.data1 = b_t[sent];
                bus.mode  = (sent % 2 == 0) ? MODE_ADD : MODE_SUB;
            end
            step();
            if (acc_s)  sent++;
            if (fire_s) got++;
            if (cyc >= 3 && cyc <= 5) begin
                check("stall_in_ready",  s_in_ready,  0);
                check("stall_out_valid", s_out_valid, 1);
                if (cyc == 3) begin
                    held_sum = s_sum;
                    held_c   = s_carry;
                    held_o   = s_ovf;
                    held_z   = s_zero;
                end else begin
                    check("stall_hold_sum",   s_sum,   held_sum);
                    check("stall_hold_carry", s_carry, held_c);
                    check("stall_hold_ovf",   s_ovf,   held_o);
                    check("stall_hold_zero",  s_zero,  held_z);
                end
            end
        end
        check("stall_sent",        sent,          6);
        check("stall_got",         got,           6);
        check("stall_queue_empty", exp_q.size(),  0);

        // Reset with two beats in flight, the older one parked at the stalled output.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = MODE_ADD;
        bus.data0     = 8'h12;
        bus.data1     = 8'h34;
        step();
        bus.data0     = 8'h21;
        bus.data1     = 8'h43;
        step();
        bus.in_valid  = 1'b0;
        step();
        check("pre_reset_out_valid", s_out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid,       0);
        check("mid_rst_sum",       bus.final_sum,       0);
        check("mid_rst_carry",     bus.final_carry_out, 0);
        check("mid_rst_overflow",  bus.overflow,        0);
        check("mid_rst_zero",      bus.zero,            0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_idle", s_out_valid, 0);
        end
        single_beat("vf0_add_0f", 8'hF0, 8'h0F, MODE_ADD, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure, then drain.
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.data0     = W'($urandom());
            bus.data1     = W'($urandom());
            bus.mode      = 1'($urandom_range(1));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        check("random_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised successor to the fixed 8-bit add/subtract unit. Computes A+B or A-B over WIDTH bits, split into CHUNK-bit carry-chained pipeline stages so wide operands still close timing. Adds a valid/ready handshake, registered flags (carry, signed overflow, zero) and an optional signed saturation mode. Sits between operand sources and downstream datapath consumers in the arithmetic test blocks.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK, with STAGES >= 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
data0  in  WIDTH  operand A
data1  in  WIDTH  operand B
mode  in  1  1 = add (A+B), 0 = subtract (A-B)
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
final_sum  out  WIDTH  result
final_carry_out  out  1  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
overflow  out  1  signed two's-complement overflow
zero  out  1  final_sum == 0

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous, active-low, on rst_n.
- Reset: every stage valid bit = 0; out_valid = 0, final_sum = 0, final_carry_out = 0, overflow = 0, zero = 0. Assertion mid-operation discards all in-flight beats immediately. No output beat after deassertion until new beats are accepted.
- Subtract: A + ~B + 1. The +1 is the carry-in to stage 0; the inversion is applied at input capture.
- Stage k, k = 0..STAGES-1:
  - Adds slice [k*CHUNK +: CHUNK] with the registered carry from stage k-1.
  - Upper operand slices are skewed forward through registers.
  - Lower result slices are deskewed so all bits leave together.
- Latency: exactly STAGES cycles from the accepting handshake (in_valid & in_ready) to out_valid, when there is no stall.
- Flags (computed in the last stage):
  - overflow = carry into MSB XOR carry out of MSB.
  - zero evaluated on the emitted final_sum.
- Handshake, with a global pipeline enable en = !out_valid | out_ready:
  - in_ready = en. in_ready must not depend combinationally on in_valid.
  - All stage registers advance only when en = 1.
  - With en = 0, outputs and in-flight beats hold stable.
  - Bubbles advance with the pipe and are not collapsed.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Simultaneous events: an accept and an emit in the same cycle are legal. A beat accepted while the output is stalled is impossible because in_ready = 0.
- mode is sampled with its operands and carried down the pipe. Beats of mixed modes in flight are legal.
- STAGES = 1: degenerates to a single registered adder with the same handshake.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: when overflow = 1, final_sum clamps to signed max (0111...1) if the true result is positive, or to signed min (1000...0) if it is negative. final_carry_out and overflow still report the raw (unclamped) values. zero is evaluated on the clamped value.
- Undefined: final_sum is the wrapped WIDTH-bit result.

Decomposition:
- Shared package addsub_pkg holds:
  - MODE_ADD = 1'b1 and MODE_SUB = 1'b0.
  - A stage record typedef: valid, mode, partial sum, carry, skewed operand remainder.
  - A function deriving STAGES.
- One sub-module is natural: addsub_chunk, a CHUNK-bit combinational add with carry-in, carry-out and carry-into-MSB. The top instantiates it STAGES times and owns all registers and the handshake.

Test Plan (WIDTH=8, CHUNK=4, latency 2):
- A=0x41, B=0xC1, mode=1 -> after 2 cycles: sum 0x02, carry 1, overflow 0, zero 0.
- A=0x7F, B=0x01, mode=1 -> sum 0x80, carry 0, overflow 1. With ADDSUB_SATURATE_EN: sum 0x7F, overflow 1.
- A=0x80, B=0x01, mode=0 -> sum 0x7F, carry 1, overflow 1 (saturated: 0x80). Then A=0x55, B=0x55, mode=0 -> sum 0x00, carry 1, zero 1.
- 6 back-to-back beats alternating mode, with out_ready low for cycles 3-5 -> in_ready low during the stall, all outputs held stable, all 6 results delivered in order with no loss or duplication.
- Assert rst_n low for 1 cycle while 2 beats are in flight -> out_valid 0 and all outputs 0 immediately; the next accepted beat (A=0xF0, B=0x0F, mode=1) emits sum 0xFF, carry 0, overflow 0 after 2 cycles.
